// File: rtl/kaiserlake_pipe_pkg.sv
// Shared types and constants for the Kaiserlake pipeline control blocks.
package kaiserlake_pipe_pkg;

  typedef enum logic [1:0] {RUN, MEMWAIT, FLUSH} state_t;

  typedef struct packed {
    logic       valid;
    logic [2:0] rd;
    logic       load;
  } sb_entry_t;

  localparam int unsigned USED_RM = 2;
  localparam int unsigned USED_RN = 1;
  localparam int unsigned USED_RD = 0;

  // A bubble carries no register usage, so it never enters the scoreboard.
  localparam logic [2:0] NOP_USED = '0;
  localparam sb_entry_t  SB_EMPTY = '0;

  function automatic logic src_match(sb_entry_t e, logic [2:0] used,
                                     logic [2:0] rm, logic [2:0] rn);
    return e.valid & ((used[USED_RM] & (rm == e.rd)) |
                      (used[USED_RN] & (rn == e.rd)));
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Decode/branch/memory status in, per-stage update enables and stall counter out.
interface pipeline_hazard_ctrl_if;
  logic        dec_valid;
  logic [2:0]  dec_num_Rm;
  logic [2:0]  dec_num_Rn;
  logic [2:0]  dec_num_Rd;
  logic [2:0]  dec_used;
  logic        dec_loads;
  logic        br_taken;
  logic        mem_req;
  logic        mem_ready;
  logic        update_front;
  logic        update_readreg;
  logic        bubble;
  logic        update_back;
  logic [15:0] stall_cnt;

  modport master (
    output dec_valid, dec_num_Rm, dec_num_Rn, dec_num_Rd, dec_used, dec_loads,
    output br_taken, mem_req, mem_ready,
    input  update_front, update_readreg, bubble, update_back, stall_cnt
  );

  modport slave (
    input  dec_valid, dec_num_Rm, dec_num_Rn, dec_num_Rd, dec_used, dec_loads,
    input  br_taken, mem_req, mem_ready,
    output update_front, update_readreg, bubble, update_back, stall_cnt
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Three-entry shift scoreboard of in-flight writers (readreg/execute/memory)
// with source matching against the decode instruction.
module hazard_scoreboard #(
  parameter bit FWD_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       advance,
  input  logic       bubble,
  input  logic       dec_valid,
  input  logic [2:0] dec_num_Rm,
  input  logic [2:0] dec_num_Rn,
  input  logic [2:0] dec_num_Rd,
  input  logic [2:0] dec_used,
  input  logic       dec_loads,
  output logic       hazard
);
  import kaiserlake_pipe_pkg::*;

  sb_entry_t  sb_rr, sb_ex, sb_mem;
  logic [2:0] used_eff;
  logic       m_rr, m_ex, m_mem;

  always_comb used_eff = bubble ? NOP_USED : dec_used;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb_rr  <= SB_EMPTY;
      sb_ex  <= SB_EMPTY;
      sb_mem <= SB_EMPTY;
    end else if (advance) begin
      sb_mem <= sb_ex;
      sb_ex  <= sb_rr;
      if (dec_valid & used_eff[USED_RD]) begin
        sb_rr.valid <= 1'b1;
        sb_rr.rd    <= dec_num_Rd;
        sb_rr.load  <= dec_loads;
      end else begin
        sb_rr <= SB_EMPTY;
      end
    end
  end

  always_comb begin
    m_rr  = dec_valid & src_match(sb_rr,  dec_used, dec_num_Rm, dec_num_Rn);
    m_ex  = dec_valid & src_match(sb_ex,  dec_used, dec_num_Rm, dec_num_Rn);
    m_mem = dec_valid & src_match(sb_mem, dec_used, dec_num_Rm, dec_num_Rn);
    // With forwarding only a load still in readreg cannot be bypassed in time.
    hazard = FWD_EN ? (m_rr & sb_rr.load) : (m_rr | m_ex | m_mem);
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush scheduler: memory freeze, branch squash, hazard stall and a
// saturating count of front-end stall cycles.
module pipeline_hazard_ctrl #(
  parameter bit          FWD_EN    = 1'b1,
  parameter int unsigned FLUSH_CYC = 2
) (
  input logic                   clk,
  input logic                   rst,
  pipeline_hazard_ctrl_if.slave bus
);
  import kaiserlake_pipe_pkg::*;

  localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYC);

  state_t      state, nxt_state;
  logic [1:0]  flush_cnt, nxt_flush_cnt, cnt_eff;
  logic        br_pending, nxt_br_pending;
  logic        freeze, br_now, flushing, hazard;
  logic [15:0] stall_cnt_q;

  hazard_scoreboard #(.FWD_EN(FWD_EN)) u_sb (
    .clk        (clk),
    .rst        (rst),
    .advance    (bus.update_back),
    .bubble     (bus.bubble),
    .dec_valid  (bus.dec_valid),
    .dec_num_Rm (bus.dec_num_Rm),
    .dec_num_Rn (bus.dec_num_Rn),
    .dec_num_Rd (bus.dec_num_Rd),
    .dec_used   (bus.dec_used),
    .dec_loads  (bus.dec_loads),
    .hazard     (hazard)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RUN;
      flush_cnt  <= '0;
      br_pending <= 1'b0;
    end else begin
      state      <= nxt_state;
      flush_cnt  <= nxt_flush_cnt;
      br_pending <= nxt_br_pending;
    end
  end

  always_comb begin
    freeze   = bus.mem_req & ~bus.mem_ready;
    br_now   = bus.br_taken | br_pending;
    // MEMWAIT keeps the flush count, so a nonzero count means a flush resumes.
    flushing = br_now | (state == FLUSH) | ((state == MEMWAIT) & (flush_cnt != '0));
    cnt_eff  = br_now ? FLUSH_LOAD : flush_cnt;

    nxt_state          = state;
    nxt_flush_cnt      = flush_cnt;
    nxt_br_pending     = br_pending;
    bus.update_front   = 1'b0;
    bus.update_readreg = 1'b0;
    bus.bubble         = 1'b0;
    bus.update_back    = 1'b0;

    if (!rst) begin
      if (freeze) begin
        nxt_state      = MEMWAIT;
        nxt_br_pending = br_pending | bus.br_taken;
      end else begin
        nxt_br_pending     = 1'b0;
        bus.update_readreg = 1'b1;
        bus.update_back    = 1'b1;
        if (flushing) begin
          bus.bubble       = 1'b1;
          bus.update_front = 1'b1;
          nxt_flush_cnt    = cnt_eff - 2'd1;
          nxt_state        = (cnt_eff == 2'd1) ? RUN : FLUSH;
        end else begin
          nxt_state        = RUN;
          bus.bubble       = hazard;
          bus.update_front = ~hazard;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cnt_q <= '0;
    else if (!bus.update_front && (stall_cnt_q != '1))
      stall_cnt_q <= stall_cnt_q + 16'd1;
  end

  always_comb bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: one instance without forwarding (dut0) and
// one with forwarding (dut1), both driven with identical stimulus.
module tb_pipeline_hazard_ctrl;
  localparam int unsigned FC = 2;
  // {update_front, update_readreg, bubble, update_back}
  localparam logic [3:0] C_RUN   = 4'b1101;
  localparam logic [3:0] C_STALL = 4'b0111;
  localparam logic [3:0] C_FLUSH = 4'b1111;
  localparam logic [3:0] C_IDLE  = 4'b0000;

  logic       clk = 1'b0;
  logic       rst;
  logic       dv, ld, bt, mreq, mrdy;
  logic [2:0] rm, rn, rd, used;
  int         checks = 0;
  int         failures = 0;

  pipeline_hazard_ctrl_if if0 ();
  pipeline_hazard_ctrl_if if1 ();

  assign if0.dec_valid = dv;   assign if1.dec_valid = dv;
  assign if0.dec_num_Rm = rm;  assign if1.dec_num_Rm = rm;
  assign if0.dec_num_Rn = rn;  assign if1.dec_num_Rn = rn;
  assign if0.dec_num_Rd = rd;  assign if1.dec_num_Rd = rd;
  assign if0.dec_used = used;  assign if1.dec_used = used;
  assign if0.dec_loads = ld;   assign if1.dec_loads = ld;
  assign if0.br_taken = bt;    assign if1.br_taken = bt;
  assign if0.mem_req = mreq;   assign if1.mem_req = mreq;
  assign if0.mem_ready = mrdy; assign if1.mem_ready = mrdy;

  pipeline_hazard_ctrl #(.FWD_EN(1'b0), .FLUSH_CYC(FC)) dut0 (
    .clk(clk), .rst(rst), .bus(if0.slave));
  pipeline_hazard_ctrl #(.FWD_EN(1'b1), .FLUSH_CYC(FC)) dut1 (
    .clk(clk), .rst(rst), .bus(if1.slave));

  always #5 clk = ~clk;

  // Reference model: in-flight writers with the number of back-end advances
  // they have seen since entering readreg (0 = readreg, 1 = execute, 2 = memory).
  typedef struct {
    int       m;
    logic [2:0] rd;
    bit       load;
    int       age;
  } rec_t;

  rec_t       wq[$];
  int         m_flush [2];
  bit         m_pend  [2];
  int         m_stall [2];
  logic [3:0] exp_ctrl [2];

  function automatic logic [3:0] act_ctrl(int k);
    if (k == 0) return {if0.update_front, if0.update_readreg, if0.bubble, if0.update_back};
    return {if1.update_front, if1.update_readreg, if1.bubble, if1.update_back};
  endfunction

  function automatic logic [15:0] act_stall(int k);
    return (k == 0) ? if0.stall_cnt : if1.stall_cnt;
  endfunction

  function automatic bit model_hazard(int k);
    if (!dv) return 1'b0;
    foreach (wq[i]) begin
      if (wq[i].m == k && ((used[2] && rm == wq[i].rd) || (used[1] && rn == wq[i].rd))) begin
        if (k == 0) return 1'b1;
        if (wq[i].age == 0 && wq[i].load) return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  task automatic model_reset();
    wq.delete();
    for (int k = 0; k < 2; k++) begin
      m_flush[k] = 0;
      m_pend[k]  = 1'b0;
      m_stall[k] = 0;
    end
  endtask

  task automatic expect_now();
    for (int k = 0; k < 2; k++) begin
      if (rst || (mreq && !mrdy))                  exp_ctrl[k] = C_IDLE;
      else if (bt || m_pend[k] || m_flush[k] > 0) exp_ctrl[k] = C_FLUSH;
      else if (model_hazard(k))                   exp_ctrl[k] = C_STALL;
      else                                        exp_ctrl[k] = C_RUN;
    end
  endtask

  task automatic commit();
    rec_t nq[$];
    rec_t r;
    logic [3:0] e;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      for (int k = 0; k < 2; k++) begin
        e = exp_ctrl[k];
        if (e == C_IDLE) begin
          m_pend[k] = m_pend[k] | bt;
        end else begin
          if (e == C_FLUSH) m_flush[k] = ((bt || m_pend[k]) ? int'(FC) : m_flush[k]) - 1;
          m_pend[k] = 1'b0;
        end
        if (e[0]) begin
          nq.delete();
          foreach (wq[i]) begin
            r = wq[i];
            if (r.m == k) r.age++;
            if (r.age < 3) nq.push_back(r);
          end
          wq = nq;
          if (dv && used[0] && !e[1]) begin
            r.m = k; r.rd = rd; r.load = ld; r.age = 0;
            wq.push_back(r);
          end
        end
        if (!e[3] && m_stall[k] < 65535) m_stall[k]++;
      end
    end
    #1;
  endtask

  task automatic set_dec(input logic v, input logic [2:0] d, input logic [2:0] n,
                         input logic [2:0] m, input logic [2:0] u, input logic l);
    dv = v; rd = d; rn = n; rm = m; used = u; ld = l;
  endtask

  task automatic do_reset();
    rst = 1'b1; bt = 1'b0; mreq = 1'b0; mrdy = 1'b0;
    set_dec(0, 0, 0, 0, 0, 0);
    model_reset();
    @(negedge clk); expect_now();
    commit();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] tab [3];
    tab = '{C_IDLE, C_IDLE, C_RUN};
    rst = 1'b1; bt = 1'b0; mreq = 1'b0; mrdy = 1'b0;
    set_dec(0, 0, 0, 0, 0, 0);
    model_reset();
    for (int c = 0; c < 3; c++) begin
      if (c == 2) rst = 1'b0;
      @(negedge clk); expect_now();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (act_ctrl(k) !== tab[c]) begin
          failures++;
          $display("FAIL reset dut%0d cyc%0d ctrl=%b expected %b", k, c, act_ctrl(k), tab[c]);
        end
        checks++;
        if (act_stall(k) !== 16'd0) begin
          failures++;
          $display("FAIL reset_stall dut%0d cyc%0d stall_cnt=%0d expected 0", k, c, act_stall(k));
        end
      end
      commit();
    end
  endtask

  task automatic test_load_use();
    logic [3:0] tab [2][6];
    tab = '{'{C_RUN, C_STALL, C_STALL, C_STALL, C_RUN, C_STALL},
            '{C_RUN, C_STALL, C_RUN,   C_RUN,   C_RUN, C_RUN}};
    do_reset();
    for (int c = 0; c < 6; c++) begin
      if (c == 0)      set_dec(1, 3, 0, 0, 3'b001, 1);
      else if (c < 5)  set_dec(1, 1, 3, 2, 3'b111, 0);
      else             set_dec(1, 5, 1, 1, 3'b111, 0);
      @(negedge clk); expect_now();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (act_ctrl(k) !== exp_ctrl[k]) begin
          failures++;
          $display("FAIL load_use_model dut%0d cyc%0d ctrl=%b expected %b", k, c, act_ctrl(k), exp_ctrl[k]);
        end
        checks++;
        if (act_ctrl(k) !== tab[k][c]) begin
          failures++;
          $display("FAIL load_use dut%0d cyc%0d ctrl=%b expected %b", k, c, act_ctrl(k), tab[k][c]);
        end
      end
      if (c == 5) begin
        checks++;
        if (act_stall(1) !== 16'd1) begin
          failures++;
          $display("FAIL load_use_stall_cnt dut1 got %0d expected 1", act_stall(1));
        end
        checks++;
        if (act_stall(0) !== 16'd3) begin
          failures++;
          $display("FAIL raw_stall_cnt dut0 got %0d expected 3", act_stall(0));
        end
      end
      commit();
    end
    set_dec(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_branch();
    logic [3:0] tab [3];
    tab = '{C_FLUSH, C_FLUSH, C_RUN};
    do_reset();
    for (int c = 0; c < 3; c++) begin
      bt = (c == 0);
      @(negedge clk); expect_now();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (act_ctrl(k) !== tab[c] || act_ctrl(k) !== exp_ctrl[k]) begin
          failures++;
          $display("FAIL branch dut%0d cyc%0d ctrl=%b expected %b", k, c, act_ctrl(k), tab[c]);
        end
        checks++;
        if (act_stall(k) !== 16'd0) begin
          failures++;
          $display("FAIL branch_stall dut%0d cyc%0d stall_cnt=%0d expected 0", k, c, act_stall(k));
        end
      end
      commit();
    end
    bt = 1'b0;
  endtask

  task automatic test_freeze();
    logic [3:0] t1 [8];
    logic [3:0] t2 [2][5];
    t1 = '{C_RUN, C_IDLE, C_IDLE, C_IDLE, C_IDLE, C_FLUSH, C_FLUSH, C_RUN};
    t2 = '{'{C_RUN, C_IDLE, C_IDLE, C_STALL, C_STALL},
           '{C_RUN, C_IDLE, C_IDLE, C_STALL, C_RUN}};
    do_reset();
    for (int c = 0; c < 8; c++) begin
      bt = (c == 2);
      if (c == 0)      set_dec(1, 3, 0, 0, 3'b001, 1);
      else if (c < 5)  set_dec(1, 1, 3, 2, 3'b111, 0);
      else             set_dec(0, 0, 0, 0, 0, 0);
      mreq = (c >= 1 && c <= 5);
      mrdy = (c == 5);
      @(negedge clk); expect_now();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (act_ctrl(k) !== t1[c] || act_ctrl(k) !== exp_ctrl[k]) begin
          failures++;
          $display("FAIL freeze_branch dut%0d cyc%0d ctrl=%b expected %b", k, c, act_ctrl(k), t1[c]);
        end
      end
      if (c == 5) begin
        for (int k = 0; k < 2; k++) begin
          checks++;
          if (act_stall(k) !== 16'd4) begin
            failures++;
            $display("FAIL freeze_stall_cnt dut%0d got %0d expected 4", k, act_stall(k));
          end
        end
      end
      commit();
    end
    do_reset();
    for (int c = 0; c < 5; c++) begin
      if (c == 0)      set_dec(1, 3, 0, 0, 3'b001, 1);
      else if (c < 3)  set_dec(0, 0, 0, 0, 0, 0);
      else             set_dec(1, 1, 3, 2, 3'b111, 0);
      mreq = (c == 1 || c == 2);
      mrdy = 1'b0;
      @(negedge clk); expect_now();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (act_ctrl(k) !== t2[k][c] || act_ctrl(k) !== exp_ctrl[k]) begin
          failures++;
          $display("FAIL freeze_hold dut%0d cyc%0d ctrl=%b expected %b", k, c, act_ctrl(k), t2[k][c]);
        end
      end
      commit();
    end
    set_dec(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_hazard_branch();
    logic [3:0] tab [4];
    tab = '{C_RUN, C_FLUSH, C_FLUSH, C_RUN};
    do_reset();
    for (int c = 0; c < 4; c++) begin
      bt = (c == 1);
      if (c == 0)      set_dec(1, 3, 0, 0, 3'b001, 1);
      else if (c < 3)  set_dec(1, 1, 3, 2, 3'b111, 0);
      else             set_dec(0, 0, 0, 0, 0, 0);
      @(negedge clk); expect_now();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (act_ctrl(k) !== tab[c] || act_ctrl(k) !== exp_ctrl[k]) begin
          failures++;
          $display("FAIL hazard_vs_branch dut%0d cyc%0d ctrl=%b expected %b", k, c, act_ctrl(k), tab[c]);
        end
      end
      commit();
    end
    bt = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      if (c == 0) set_dec(1, 3, 0, 0, 3'b001, 1);
      else        set_dec(0, 0, 0, 0, 0, 0);
      mreq = (c == 1 || c == 2);
      mrdy = 1'b0;
      bt   = (c == 3);
      @(negedge clk); expect_now();
      commit();
    end
    bt = 1'b0;
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (act_ctrl(k) !== C_IDLE) begin
        failures++;
        $display("FAIL async_reset dut%0d ctrl=%b expected %b", k, act_ctrl(k), C_IDLE);
      end
      checks++;
      if (act_stall(k) !== 16'd0) begin
        failures++;
        $display("FAIL async_reset_stall dut%0d stall_cnt=%0d expected 0", k, act_stall(k));
      end
    end
    model_reset();
    @(negedge clk); expect_now();
    commit();
    rst = 1'b0;
    set_dec(1, 1, 3, 2, 3'b111, 0);
    @(negedge clk); expect_now();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (act_ctrl(k) !== C_RUN || act_stall(k) !== 16'd0) begin
        failures++;
        $display("FAIL post_reset dut%0d ctrl=%b stall_cnt=%0d expected %b and 0",
                 k, act_ctrl(k), act_stall(k), C_RUN);
      end
    end
    commit();
    set_dec(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(99) < 2) begin
        rst = 1'b1;
        model_reset();
      end else begin
        rst = 1'b0;
      end
      set_dec($urandom_range(99) < 80, 3'($urandom_range(7)), 3'($urandom_range(7)),
              3'($urandom_range(7)), 3'($urandom_range(7)), $urandom_range(99) < 35);
      bt   = ($urandom_range(99) < 10);
      mreq = ($urandom_range(99) < 25);
      mrdy = ($urandom_range(99) < 50);
      @(negedge clk); expect_now();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (act_ctrl(k) !== exp_ctrl[k]) begin
          failures++;
          $display("FAIL random_ctrl dut%0d cyc%0d ctrl=%b expected %b", k, c, act_ctrl(k), exp_ctrl[k]);
        end
        checks++;
        if (act_stall(k) !== 16'(m_stall[k])) begin
          failures++;
          $display("FAIL random_stall dut%0d cyc%0d stall_cnt=%0d expected %0d", k, c, act_stall(k), m_stall[k]);
        end
      end
      commit();
    end
    rst = 1'b0; bt = 1'b0; mreq = 1'b0; mrdy = 1'b0;
    set_dec(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_freeze();
    test_hazard_branch();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush scheduler for the 5-stage Kaiserlake pipeline. It tracks in-flight register writers in the readreg, execute and memory stages and detects load-use and RAW hazards against the instruction in decode. It drives the `update` enables of all pipeline-register stages and freezes the pipe while data memory is busy. It also squashes wrong-path instructions after a taken branch and keeps a stall-cycle performance counter.

## Interface
Parameters:
- FWD_EN, 1: 1 = execute has forwarding from MEM/WB, so only load-use hazards stall; 0 = no forwarding, so any pending writer stalls.
- FLUSH_CYC, 2: number of cycles a bubble is injected after a taken branch (1..3).

Ports:
- clk  in  1  pipeline clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- dec_valid  in  1  decode holds a real instruction.
- dec_num_Rm, dec_num_Rn, dec_num_Rd  in  3 each  register numbers of the decode instruction.
- dec_used  in  3  [2] Rm read, [1] Rn read, [0] Rd written.
- dec_loads  in  1  decode instruction is a load.
- br_taken  in  1  execute resolved a taken branch (one-cycle pulse).
- mem_req  in  1  memory stage holds an access.
- mem_ready  in  1  data memory completes the access this cycle.
- update_front  out  1  enable for the fetch/decode stage registers.
- update_readreg  out  1  enable for the readreg stage registers.
- bubble  out  1  readreg captures a NOP (control = 0, used = 0) instead of decode outputs.
- update_back  out  1  enable for the execute/memory/writeback stage registers.
- stall_cnt  out  16  saturating count of cycles with update_front = 0.

## Operation
- Scoreboard: three entries SB_RR, SB_EX, SB_MEM, each {valid, rd[2:0], load}.
- Scoreboard advance: on every cycle with update_back = 1, SB_MEM <= SB_EX, SB_EX <= SB_RR.
- SB_RR load on advance: SB_RR <= {1, dec_num_Rd, dec_loads} when dec_valid & dec_used[0] & ~bubble; otherwise it is cleared.
- Scoreboard when frozen: holds its contents.
- Source match: (dec_used[2] & Rm == e.rd) | (dec_used[1] & Rn == e.rd), qualified by e.valid and dec_valid.
- Hazard, FWD_EN = 1: source match on SB_RR with SB_RR.load.
- Hazard, FWD_EN = 0: source match on any of SB_RR, SB_EX or SB_MEM.
- Freeze: mem_req & ~mem_ready. Forces update_front = update_readreg = update_back = 0 and bubble = 0.
- FSM states:
  - RUN: normal operation.
  - MEMWAIT: entered from RUN/FLUSH when freeze is true. Outputs are frozen. Returns to the prior state class on mem_ready; a saved flush count is resumed.
  - FLUSH: entered when br_taken is seen while not frozen, or on a pending branch at freeze release. Loads flush_cnt = FLUSH_CYC. Each unfrozen cycle sets bubble = 1, update_front = 1 and decrements flush_cnt. Returns to RUN when flush_cnt reaches 0.
- br_taken arriving during freeze sets br_pending. The pending branch is applied on the first unfrozen cycle.
- br_taken during FLUSH reloads flush_cnt = FLUSH_CYC.
- Priority: rst > freeze > flush > hazard stall > run.
- Hazard stall (RUN, no freeze): update_front = 0, update_readreg = 1, bubble = 1, update_back = 1.
- Run: all updates = 1, bubble = 0.
- A hazard during FLUSH is ignored, because the instruction is squashed anyway.
- stall_cnt increments on every cycle with update_front = 0, except while rst is asserted. It saturates at 16'hFFFF.

## Timing
- All control outputs are combinational from the current state and same-cycle inputs, with no added latency. The scoreboard and FSM update on the edge.
- Load-use with FWD_EN = 1: exactly 1 bubble.
- RAW with FWD_EN = 0: up to 3 bubbles, with the stall releasing one cycle after the matching writer leaves SB_MEM.
- Taken branch: FLUSH_CYC bubbles, starting in the cycle br_taken is high.
- Reset behaviour:
  - While rst is high: all update_* = 0, bubble = 0.
  - Reset values: state RUN, scoreboard cleared, br_pending = 0, flush_cnt = 0, stall_cnt = 0.
  - Reset mid-freeze or mid-flush discards all pending work.
  - The first cycle after release is RUN with all updates = 1.
- mem_ready without mem_req is ignored.

## Structure
- Shared package kaiserlake_pipe_pkg:
  - state enum {RUN, MEMWAIT, FLUSH}.
  - sb_entry_t struct.
  - USED_RM = 2, USED_RN = 1, USED_RD = 0.
  - NOP control constant for bubble insertion.
- Sub-module hazard_scoreboard: the 3-entry shift scoreboard plus match logic. Outputs hazard.
- Top-level contents: FSM, flush counter, br_pending and stall_cnt.

## Test plan
- LDR R3 then ADD R1,R3,R2 back-to-back, FWD_EN = 1 -> one cycle with update_front = 0 and bubble = 1; stall_cnt = 1. No stall for ADD then ADD.
- FWD_EN = 0, MOV R4 then use of R4 -> update_front = 0 for 3 cycles, releasing the 4th; stall_cnt = 3.
- br_taken pulse, FLUSH_CYC = 2 -> bubble = 1 for 2 cycles with update_front = 1, then RUN.
- mem_req = 1, mem_ready = 0 for 4 cycles, with br_taken pulsed in the 2nd cycle -> all updates = 0 for 4 cycles and the scoreboard is held. Then FLUSH starts on the release cycle; stall_cnt = 4.
- Load-use hazard coinciding with br_taken -> flush wins, with bubble = 1 and update_front = 1.
- rst asserted asynchronously mid-FLUSH -> outputs go to 0 immediately; after release, RUN with scoreboard empty and stall_cnt = 0.
